aes_block_uart_tx: RTL and testbench

Downstream stage of the AES `Cipher` core. It accepts one 128-bit ciphertext block through a valid/ready handshake and serializes it as 16 bytes to the UART transmitter (`uart_wrapper`). Bytes go out most-significant first, and each byte is paced by the transmitter's `O_BUSY` signal. The block sits between the cipher output and the `I_TX_DATA`/`I_TX_START`/`O_BUSY` port group of the UART.

---
 rtl/aes_block_uart_tx_if.sv | 26 ++
 rtl/aes_block_uart_tx.sv | 122 ++++++++++++
 tb/tb_aes_block_uart_tx.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_uart_tx_if.sv
// Signal bundle between the AES block serializer, its block source and the UART transmitter.
interface aes_block_uart_tx_if #(
    parameter int NUM_BYTES = 16
);
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic [8*NUM_BYTES-1:0] I_BLOCK;
    logic                   I_BLOCK_VLD;
    logic                   O_BLOCK_RDY;
    logic [7:0]             O_TX_DATA;
    logic                   O_TX_START;
    logic                   I_TX_BUSY;
    logic                   O_DONE;
    logic                   O_ERR;
    logic [IDX_W-1:0]       O_BYTE_IDX;

    modport slave (
        input  I_BLOCK, I_BLOCK_VLD, I_TX_BUSY,
        output O_BLOCK_RDY, O_TX_DATA, O_TX_START, O_DONE, O_ERR, O_BYTE_IDX
    );

    modport master (
        output I_BLOCK, I_BLOCK_VLD, I_TX_BUSY,
        input  O_BLOCK_RDY, O_TX_DATA, O_TX_START, O_DONE, O_ERR, O_BYTE_IDX
    );
endinterface

// File: rtl/aes_block_uart_tx.sv
// Serializes one ciphertext block into UART bytes, most-significant byte first, paced by busy.
module aes_block_uart_tx #(
    parameter int NUM_BYTES    = 16,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               CLK100M,
    input  logic               CPU_RESETN,
    aes_block_uart_tx_if.slave bus
);
    localparam int BLK_W   = 8 * NUM_BYTES;
    localparam int IDX_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_MAX = (BUSY_TIMEOUT > 255) ? BUSY_TIMEOUT : 255;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP} state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Next-state logic; every output is the registered image of a value decided here.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdy_q && bus.I_BLOCK_VLD) begin
                    shift_d = bus.I_BLOCK;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.I_TX_BUSY) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.I_TX_BUSY) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q << 8;
                        cnt_d   = '0;
                        state_d = (GAP_CYCLES == 0) ? START : GAP;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready stays low for the cycle that ends a block, so done/err precede the next accept.
        rdy_d   = (state_q == IDLE) && (state_d == IDLE);
        start_d = (state_d == START);
        data_d  = start_d ? shift_d[BLK_W-1 -: 8] : data_q;
    end

    always_ff @(posedge CLK100M or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.O_BLOCK_RDY = rdy_q;
    assign bus.O_TX_DATA   = data_q;
    assign bus.O_TX_START  = start_q;
    assign bus.O_DONE      = done_q;
    assign bus.O_ERR       = err_q;
    assign bus.O_BYTE_IDX  = idx_q;
endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Scoreboard bench for aes_block_uart_tx: one instance without gap, one with a 3-cycle gap.
`timescale 1ns/1ps
module tb_aes_block_uart_tx;
    localparam int NB = 16;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    aes_block_uart_tx_if #(.NUM_BYTES(NB)) if0 ();
    aes_block_uart_tx_if #(.NUM_BYTES(NB)) if1 ();

    aes_block_uart_tx #(.NUM_BYTES(NB), .GAP_CYCLES(0), .BUSY_TIMEOUT(TO)) dut0 (
        .CLK100M(clk), .CPU_RESETN(rstn), .bus(if0)
    );
    aes_block_uart_tx #(.NUM_BYTES(NB), .GAP_CYCLES(3), .BUSY_TIMEOUT(TO)) dut1 (
        .CLK100M(clk), .CPU_RESETN(rstn), .bus(if1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] expQ0[$];
    int         idxQ0[$];
    logic [7:0] expQ1[$];
    int         idxQ1[$];

    int busyLen0 = 20;
    int busyLen1 = 5;
    bit failArm  = 1'b0;
    int failIdx  = 3;

    int doneCnt0 = 0, errCnt0 = 0, doneCnt1 = 0;
    int lastFall0 = -1, lastFall1 = -1;
    int failStart = -1, doneCyc0 = -1, seenIdx0 = -1;
    bit b2bCheck = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        checks++;
        if (act !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expVal, cyc);
        end
    endtask

    // Cycle counter advanced on the active edge; monitors read it on the falling edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART model for dut0: busy rises the cycle after a start and stays high busyLen0 cycles.
    initial begin : uart0
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        if0.I_TX_BUSY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                if0.I_TX_BUSY = 1'b0;
                cnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if0.I_TX_BUSY = 1'b1;
                    cnt = busyLen0;
                    pend = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) if0.I_TX_BUSY = 1'b0;
                end
                if (if0.O_TX_START && !(failArm && (32'(if0.O_BYTE_IDX) == failIdx))) pend = 1'b1;
            end
        end
    end

    initial begin : uart1
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        if1.I_TX_BUSY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                if1.I_TX_BUSY = 1'b0;
                cnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if1.I_TX_BUSY = 1'b1;
                    cnt = busyLen1;
                    pend = 1'b0;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) if1.I_TX_BUSY = 1'b0;
                end
                if (if1.O_TX_START) pend = 1'b1;
            end
        end
    end

    // Monitor for dut0: pops expected bytes on each start, checks pacing, done/err and ready.
    initial begin : mon0
        bit prevBusy, prevDone, prevErr;
        logic [7:0] curData;
        logic [7:0] expByte;
        int expIdx;
        prevBusy = 1'b0; prevDone = 1'b0; prevErr = 1'b0;
        curData = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prevBusy = 1'b0; prevDone = 1'b0; prevErr = 1'b0;
                lastFall0 = -1;
            end else begin
                if (prevDone || prevErr) checkOutput("rdyAfterEnd0", 32'(if0.O_BLOCK_RDY), 32'd1);
                if (prevBusy && !if0.I_TX_BUSY) lastFall0 = cyc;
                if (if0.O_TX_START) begin
                    if (expQ0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedStart0: got data 0x%0h idx %0d, required no start", if0.O_TX_DATA, if0.O_BYTE_IDX);
                    end else begin
                        expByte = expQ0.pop_front();
                        expIdx  = idxQ0.pop_front();
                        checkOutput("txData0", 32'(if0.O_TX_DATA), 32'(expByte));
                        checkOutput("byteIdx0", 32'(if0.O_BYTE_IDX), 32'(expIdx));
                    end
                    checkOutput("rdyDuringBlock0", 32'(if0.O_BLOCK_RDY), 32'd0);
                    if (lastFall0 >= 0) checkOutput("gapTiming0", 32'(cyc - lastFall0), 32'd1);
                    if (b2bCheck && doneCyc0 >= 0) begin
                        checkOutput("b2bStart", 32'(cyc - doneCyc0), 32'd2);
                        doneCyc0 = -1;
                    end
                    lastFall0 = -1;
                    curData = if0.O_TX_DATA;
                    seenIdx0 = 32'(if0.O_BYTE_IDX);
                    if (failArm && (32'(if0.O_BYTE_IDX) == failIdx)) failStart = cyc;
                end
                if (if0.I_TX_BUSY) checkOutput("dataStable0", 32'(if0.O_TX_DATA), 32'(curData));
                if (if0.O_DONE) begin
                    doneCnt0++;
                    doneCyc0 = cyc;
                    lastFall0 = -1;
                    checkOutput("rdyAtDone0", 32'(if0.O_BLOCK_RDY), 32'd0);
                end
                if (if0.O_ERR) begin
                    errCnt0++;
                    checkOutput("errLatency", 32'(cyc - failStart), 32'(TO + 1));
                    checkOutput("rdyAtErr", 32'(if0.O_BLOCK_RDY), 32'd0);
                end
                prevBusy = if0.I_TX_BUSY;
                prevDone = if0.O_DONE;
                prevErr  = if0.O_ERR;
            end
        end
    end

    // Monitor for dut1: byte order, 3 idle cycles after each busy fall, data stable while busy.
    initial begin : mon1
        bit prevBusy;
        logic [7:0] curData;
        logic [7:0] expByte;
        int expIdx;
        prevBusy = 1'b0;
        curData = 8'h00;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prevBusy = 1'b0;
                lastFall1 = -1;
            end else begin
                if (prevBusy && !if1.I_TX_BUSY) lastFall1 = cyc;
                if (if1.O_TX_START) begin
                    if (expQ1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedStart1: got data 0x%0h idx %0d, required no start", if1.O_TX_DATA, if1.O_BYTE_IDX);
                    end else begin
                        expByte = expQ1.pop_front();
                        expIdx  = idxQ1.pop_front();
                        checkOutput("txData1", 32'(if1.O_TX_DATA), 32'(expByte));
                        checkOutput("byteIdx1", 32'(if1.O_BYTE_IDX), 32'(expIdx));
                    end
                    if (lastFall1 >= 0) checkOutput("gapTiming1", 32'(cyc - lastFall1), 32'd4);
                    lastFall1 = -1;
                    curData = if1.O_TX_DATA;
                end
                if (if1.I_TX_BUSY) checkOutput("dataStable1", 32'(if1.O_TX_DATA), 32'(curData));
                if (if1.O_DONE) begin
                    doneCnt1++;
                    lastFall1 = -1;
                end
                prevBusy = if1.I_TX_BUSY;
            end
        end
    end

    task automatic pushExpected(input int sel, input logic [127:0] blk, input int nExp);
        for (int k = 0; k < nExp; k++) begin
            if (sel == 0) begin
                expQ0.push_back(blk[8*(NB-k)-1 -: 8]);
                idxQ0.push_back(k);
            end else begin
                expQ1.push_back(blk[8*(NB-k)-1 -: 8]);
                idxQ1.push_back(k);
            end
        end
    endtask

    // Offers one block, waits for ready, and checks the first start follows the accept edge.
    task automatic applyStimulus(input int sel, input logic [127:0] blk, input int nExp);
        bit ok;
        pushExpected(sel, blk, nExp);
        @(posedge clk);
        #1;
        if (sel == 0) begin if0.I_BLOCK = blk; if0.I_BLOCK_VLD = 1'b1; end
        else          begin if1.I_BLOCK = blk; if1.I_BLOCK_VLD = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((sel == 0) ? if0.O_BLOCK_RDY : if1.O_BLOCK_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("acceptInTime", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            if0.I_BLOCK_VLD = 1'b0;
            checkOutput("firstStart0", 32'(if0.O_TX_START), 32'd1);
        end else begin
            if1.I_BLOCK_VLD = 1'b0;
            checkOutput("firstStart1", 32'(if1.O_TX_START), 32'd1);
        end
    endtask

    task automatic waitDone(input int sel, input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (((sel == 0) ? doneCnt0 : doneCnt1) >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("doneInTime", 32'(ok), 32'd1);
    endtask

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h102132435465768798A9BACBDCEDFE0F;
    localparam logic [127:0] BLK_C = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] BLK_D = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] BLK_E = 128'hDEADBEEF0123456789ABCDEFF0E1D2C3;

    initial begin : stim
        bit ok;
        if0.I_BLOCK = '0; if0.I_BLOCK_VLD = 1'b0;
        if1.I_BLOCK = '0; if1.I_BLOCK_VLD = 1'b0;

        $display("[TB] reset check");
        rstn = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("rstRdy", 32'(if0.O_BLOCK_RDY), 32'd0);
        checkOutput("rstData", 32'(if0.O_TX_DATA), 32'h00);
        checkOutput("rstStart", 32'(if0.O_TX_START), 32'd0);
        checkOutput("rstDone", 32'(if0.O_DONE), 32'd0);
        checkOutput("rstErr", 32'(if0.O_ERR), 32'd0);
        checkOutput("rstIdx", 32'(if0.O_BYTE_IDX), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rdyAfterReset0", 32'(if0.O_BLOCK_RDY), 32'd1);
        checkOutput("rdyAfterReset1", 32'(if1.O_BLOCK_RDY), 32'd1);

        $display("[TB] single block, busy 20 cycles");
        checkOutput("blkAByte0", 32'(BLK_A[127:120]), 32'h00);
        applyStimulus(0, BLK_A, NB);
        waitDone(0, 1);
        repeat (3) @(negedge clk);
        checkOutput("doneCountA", 32'(doneCnt0), 32'd1);
        checkOutput("queueEmptyA", 32'(expQ0.size()), 32'd0);

        $display("[TB] gap of 3 cycles, busy 5 cycles");
        applyStimulus(1, BLK_E, NB);
        waitDone(1, 1);
        repeat (3) @(negedge clk);
        checkOutput("doneCount1", 32'(doneCnt1), 32'd1);
        checkOutput("queueEmpty1", 32'(expQ1.size()), 32'd0);

        $display("[TB] busy timeout on byte 3");
        failIdx = 3;
        failArm = 1'b1;
        applyStimulus(0, BLK_B, 4);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (errCnt0 >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("errInTime", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("errCount", 32'(errCnt0), 32'd1);
        checkOutput("noDoneOnErr", 32'(doneCnt0), 32'd1);
        checkOutput("rdyAfterErr", 32'(if0.O_BLOCK_RDY), 32'd1);
        checkOutput("queueEmptyB", 32'(expQ0.size()), 32'd0);
        failArm = 1'b0;
        applyStimulus(0, BLK_C, NB);
        waitDone(0, 2);

        $display("[TB] reset during byte 7");
        seenIdx0 = -1;
        applyStimulus(0, BLK_D, 8);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (seenIdx0 == 7) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("reachedByte7", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midRstStart", 32'(if0.O_TX_START), 32'd0);
        checkOutput("midRstData", 32'(if0.O_TX_DATA), 32'h00);
        checkOutput("midRstIdx", 32'(if0.O_BYTE_IDX), 32'd0);
        checkOutput("midRstRdy", 32'(if0.O_BLOCK_RDY), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("queueEmptyD", 32'(expQ0.size()), 32'd0);
        checkOutput("doneCountD", 32'(doneCnt0), 32'd2);
        applyStimulus(0, BLK_A, NB);
        waitDone(0, 3);

        $display("[TB] two blocks with valid held high");
        doneCyc0 = -1;
        b2bCheck = 1'b1;
        pushExpected(0, BLK_D, NB);
        pushExpected(0, BLK_E, NB);
        @(posedge clk);
        #1;
        if0.I_BLOCK = BLK_D;
        if0.I_BLOCK_VLD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if0.O_BLOCK_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("b2bFirstAccept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if0.I_BLOCK = BLK_E;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (if0.O_BLOCK_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("b2bSecondAccept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if0.I_BLOCK_VLD = 1'b0;
        waitDone(0, 5);
        repeat (5) @(negedge clk);
        checkOutput("doneCountB2B", 32'(doneCnt0), 32'd5);
        checkOutput("queueEmptyB2B", 32'(expQ0.size()), 32'd0);
        checkOutput("errCountFinal", 32'(errCnt0), 32'd1);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
